// File: rtl/cpu_bus_pkg.sv
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared arbiter state, owner and transfer-size encodings.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sram_like_arb_pick.sv
// ============================================================================
// Module      : sram_like_arb_pick
// Description : Combinational winner select between instruction and data
//               requests. SRAM_ARB_RR_EN selects round-robin on ties.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_like_arb_pick
  import cpu_bus_pkg::*;
(
  input  logic   i_inst_req,
  input  logic   i_data_req,
`ifdef SRAM_ARB_RR_EN
  input  owner_t i_last_grant,
`endif
  output logic   o_valid,
  output owner_t o_winner
);

  always_comb begin
    o_valid  = i_inst_req | i_data_req;
    o_winner = i_data_req ? OWN_DATA : OWN_INST;
`ifdef SRAM_ARB_RR_EN
    // On a tie, hand the bus to whichever port did not win last time.
    if (i_inst_req && i_data_req) begin
      o_winner = (i_last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// Module      : sram_like_arbiter
// Description : Shares one SRAM-like master bus between the instruction and
//               data ports, one transaction in flight. SRAM_ARB_RR_EN enables
//               round-robin arbitration (default: data has fixed priority).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  output logic              busy
);

  import cpu_bus_pkg::*;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  owner_t            r_owner;
  owner_t            w_winner;
  logic              w_grant_valid;
  logic              w_accept;
  logic              w_done;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

`ifdef SRAM_ARB_RR_EN
  owner_t            r_last_grant;
`endif

  sram_like_arb_pick u_pick (
    .i_inst_req   (inst_req),
    .i_data_req   (data_req),
`ifdef SRAM_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_valid      (w_grant_valid),
    .o_winner     (w_winner)
  );

  // rstn gating keeps addr_ok low while reset is held even if a req lingers.
  assign w_accept = rstn && (r_state == ST_IDLE) && w_grant_valid;
  assign w_done   = (r_state == ST_WAIT) && m_data_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    m_req        = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = ST_ISSUE;
          inst_addr_ok = (w_winner == OWN_INST);
          data_addr_ok = (w_winner == OWN_DATA);
        end
      end
      ST_ISSUE: begin
        m_req = 1'b1;
        if (m_addr_ok) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
          if (r_owner == OWN_INST) begin
            inst_data_ok = 1'b1;
            inst_rdata   = m_rdata;
          end else begin
            data_data_ok = 1'b1;
            data_rdata   = m_rdata;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner <= OWN_INST;
      r_wr    <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_owner <= w_winner;
      if (w_winner == OWN_DATA) begin
        r_wr    <= data_wr;
        r_size  <= data_size;
        r_addr  <= data_addr;
        r_wdata <= data_wdata;
      end else begin
        r_wr    <= inst_wr;
        r_size  <= inst_size;
        r_addr  <= inst_addr;
        r_wdata <= inst_wdata;
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_grant <= OWN_INST;
    end else if (w_accept) begin
      r_last_grant <= w_winner;
    end
  end
`endif

  assign m_wr    = r_wr;
  assign m_size  = r_size;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// Module      : tb_sram_like_arbiter
// Description : Directed self-checking bench for sram_like_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

  logic        clk;
  logic        rstn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_checks = 0;
  int n_errors = 0;
  bit rr_mode;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .m_req        (m_req),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .m_addr_ok    (m_addr_ok),
    .m_data_ok    (m_data_ok),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
  endtask

  // Step to the middle of the next cycle; outputs settle #1 after inputs change.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_data;
`ifdef SRAM_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    clear_inputs();
    rstn = 0;
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mreq", m_req, 0);
    check_eq("rst_maddr", m_addr, 0);
    check_eq("rst_mwr", m_wr, 0);
    check_eq("rst_dataok", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 0);
    next_cycle(); rstn = 1;

    // Single inst read, zero-wait memory
    next_cycle(); inst_req = 1; inst_addr = 32'hBFC0_0000; #1;
    check_eq("t1_iaok", inst_addr_ok, 1);
    check_eq("t1_daok", data_addr_ok, 0);
    check_eq("t1_mreq_n", m_req, 0);
    next_cycle(); inst_req = 0; m_addr_ok = 1; #1;
    check_eq("t1_mreq", m_req, 1);
    check_eq("t1_maddr", m_addr, 32'hBFC0_0000);
    check_eq("t1_mwr", m_wr, 0);
    check_eq("t1_busy", busy, 1);
    next_cycle(); m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h2402_0001; #1;
    check_eq("t1_idok", inst_data_ok, 1);
    check_eq("t1_irdata", inst_rdata, 32'h2402_0001);
    check_eq("t1_ddok", data_data_ok, 0);
    check_eq("t1_drdata", data_rdata, 0);
    check_eq("t1_mreq_w", m_req, 0);
    next_cycle(); clear_inputs(); #1;
    check_eq("t1_busy_end", busy, 0);

    // Simultaneous requests: data write wins
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    inst_req = 1; inst_addr = 32'h8000_0000; #1;
    check_eq("t2_daok", data_addr_ok, 1);
    check_eq("t2_iaok", inst_addr_ok, 0);
    next_cycle(); data_req = 0; data_wr = 0; m_addr_ok = 1; #1;
    check_eq("t2_mreq", m_req, 1);
    check_eq("t2_mwr", m_wr, 1);
    check_eq("t2_mwdata", m_wdata, 32'hDEAD_BEEF);
    check_eq("t2_maddr", m_addr, 32'h8000_0010);
    check_eq("t2_msize", m_size, 2);
    check_eq("t2_iaok_issue", inst_addr_ok, 0);
    next_cycle(); m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1234_5678; #1;
    check_eq("t2_ddok", data_data_ok, 1);
    check_eq("t2_idok", inst_data_ok, 0);
    check_eq("t2_iaok_wait", inst_addr_ok, 0);
    check_eq("t2_irdata", inst_rdata, 0);
    next_cycle(); m_data_ok = 0; #1;
    check_eq("t2_iaok_late", inst_addr_ok, 1);
    next_cycle(); inst_req = 0; m_addr_ok = 1; #1;
    check_eq("t2_maddr_i", m_addr, 32'h8000_0000);
    check_eq("t2_mwr_i", m_wr, 0);
    next_cycle(); m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h3C1D_8000; #1;
    check_eq("t2_idok2", inst_data_ok, 1);
    check_eq("t2_irdata2", inst_rdata, 32'h3C1D_8000);
    next_cycle(); clear_inputs();

    // Slow memory with a stray m_data_ok during ISSUE
    data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h0000_2004;
    data_wdata = 32'h0000_CAFE; inst_req = 1; inst_addr = 32'h0000_0100; #1;
    check_eq("t3_daok", data_addr_ok, 1);
    next_cycle(); data_req = 0;
    for (int i = 0; i < 5; i++) begin
      m_addr_ok = 0; m_data_ok = (i == 2); m_rdata = 32'hFFFF_0000; #1;
      check_eq("t3_mreq", m_req, 1);
      check_eq("t3_maddr", m_addr, 32'h0000_2004);
      check_eq("t3_msize", m_size, 1);
      check_eq("t3_mwdata", m_wdata, 32'h0000_CAFE);
      check_eq("t3_aok", {inst_addr_ok, data_addr_ok}, 0);
      check_eq("t3_dok", {inst_data_ok, data_data_ok}, 0);
      next_cycle();
    end
    m_data_ok = 0; m_addr_ok = 1; #1;
    check_eq("t3_mreq_acc", m_req, 1);
    next_cycle(); m_addr_ok = 0; m_data_ok = 1; #1;
    check_eq("t3_ddok", data_data_ok, 1);
    check_eq("t3_iaok_wait", inst_addr_ok, 0);
    next_cycle(); m_data_ok = 0; #1;
    check_eq("t3_iaok", inst_addr_ok, 1);
    next_cycle(); inst_req = 0; m_addr_ok = 1; #1;
    check_eq("t3_maddr_i", m_addr, 32'h0000_0100);
    next_cycle(); m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h0000_00AA; #1;
    check_eq("t3_irdata", inst_rdata, 32'h0000_00AA);
    next_cycle(); clear_inputs();

    // Reset while waiting for m_data_ok
    inst_req = 1; inst_addr = 32'h0000_0400; #1;
    check_eq("t4_iaok", inst_addr_ok, 1);
    next_cycle(); inst_req = 0; m_addr_ok = 1;
    next_cycle(); m_addr_ok = 0; #1;
    check_eq("t4_busy_wait", busy, 1);
    next_cycle(); rstn = 0; m_data_ok = 1; m_rdata = 32'h55; #1;
    check_eq("t4_busy_rst", busy, 0);
    check_eq("t4_maddr_rst", m_addr, 0);
    check_eq("t4_dok_rst", {inst_data_ok, data_data_ok}, 0);
    check_eq("t4_irdata_rst", inst_rdata, 0);
    next_cycle(); rstn = 1; #1;
    check_eq("t4_dok_late", {inst_data_ok, data_data_ok}, 0);
    next_cycle(); m_data_ok = 0; #1;
    check_eq("t4_busy_after", busy, 0);

    // Stray m_data_ok in IDLE
    next_cycle(); m_data_ok = 1; m_rdata = 32'h77; #1;
    check_eq("t5_dok", {inst_data_ok, data_data_ok}, 0);
    check_eq("t5_irdata", inst_rdata, 0);
    next_cycle(); m_data_ok = 0; #1;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_mreq", m_req, 0);

    // Continuous requests from both ports
    inst_req = 1; inst_addr = 32'h0000_00A0;
    data_req = 1; data_addr = 32'h0000_00B0;
    for (int t = 0; t < 4; t++) begin
      exp_data = rr_mode ? (t % 2 == 0) : 1'b1;
      m_data_ok = 0; #1;
      check_eq("t6_daok", data_addr_ok, exp_data);
      check_eq("t6_iaok", inst_addr_ok, !exp_data);
      next_cycle(); m_addr_ok = 1; #1;
      check_eq("t6_maddr", m_addr, exp_data ? 32'h0000_00B0 : 32'h0000_00A0);
      next_cycle(); m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'(t + 1); #1;
      check_eq("t6_dok", {inst_data_ok, data_data_ok}, exp_data ? 2'b01 : 2'b10);
      next_cycle();
    end
    clear_inputs();
    next_cycle(); next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
